// File: rtl/tot_trigger_multi_pkg.sv
// Shared defaults and helpers for the multi-channel Time-over-Threshold trigger.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tot_trigger_multi_pkg;

  localparam int TOT_NCH     = 3;    // PMT channels
  localparam int TOT_ADC_W   = 12;   // ADC sample / threshold width
  localparam int TOT_WIN     = 120;  // occupancy window, in strobes
  localparam int TOT_OCC_W   = 7;    // 2**TOT_OCC_W > TOT_WIN
  localparam int TOT_MULT_W  = 2;    // 2**TOT_MULT_W > TOT_NCH
  localparam int TOT_HOLD_W  = 8;    // holdoff counter width
  localparam int TOT_MAX_NCH = 32;   // widest channel vector popcount() accepts

  // Number of set bits in a channel-hit vector (zero-extended to TOT_MAX_NCH).
  function automatic logic [5:0] popcount(input logic [TOT_MAX_NCH-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < TOT_MAX_NCH; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tot_occ_window.sv
// Sliding occupancy window: WIN-deep shift register of strobe bits plus a live up/down count of set bits.
// Latency: OCC reflects SB one strobe after it is presented.
// Backpressure: none; advances only on SAMPLE_EN, CLR wins over the shift on the same strobe.
//
// Ports:
//   CLK120     in  clock
//   RESET_N    in  synchronous reset, active low
//   SAMPLE_EN  in  strobe; all state holds while low
//   SB         in  bit entering the window this strobe
//   CLR        in  empty the window and zero the count (trigger fired)
//   OCC        out number of set bits currently in the window, 0..WIN
module tot_occ_window
  import tot_trigger_multi_pkg::*;
#(
  parameter int WIN   = TOT_WIN,
  parameter int OCC_W = TOT_OCC_W
) (
  input  logic             CLK120,
  input  logic             RESET_N,
  input  logic             SAMPLE_EN,
  input  logic             SB,
  input  logic             CLR,
  output logic [OCC_W-1:0] OCC
);

  logic [WIN-1:0] window;
  logic           out_bit;

  assign out_bit = window[WIN-1];

  always_ff @(posedge CLK120) begin
    if (!RESET_N) begin
      window <= '0;
      OCC    <= '0;
    end else if (SAMPLE_EN) begin
      if (CLR) begin
        window <= '0;
        OCC    <= '0;
      end else begin
        window <= {window[WIN-2:0], SB};
        // Count tracks the window contents exactly; the bounds guards only
        // keep it from wrapping should the two ever disagree.
        if (SB && !out_bit && (OCC != OCC_W'(WIN))) begin
          OCC <= OCC + OCC_W'(1);
        end else if (!SB && out_bit && (OCC != '0)) begin
          OCC <= OCC - OCC_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tot_trigger_multi.sv
// Parametrised ToT trigger: per-channel threshold compare, multiplicity, windowed occupancy, holdoff and edge pulse.
// Latency: 6 strobes from ADC capture to TRIG (18 CLK120 cycles with a 1-in-3 strobe).
// Backpressure: none; SAMPLE_EN low freezes all state and keeps TRIG low.
//
// Ports:
//   CLK120        in  120 MHz clock
//   RESET_N       in  synchronous reset, active low (acts regardless of SAMPLE_EN)
//   SAMPLE_EN     in  sample strobe
//   ADC, THRES    in  packed per-channel samples / thresholds, ch0 in LSBs
//   TRIG_ENABLE   in  per-channel enable
//   MULTIPLICITY  in  minimum channels over threshold; 0 disables
//   OCCUPANCY     in  fire when occupancy exceeds this
//   HOLDOFF       in  strobes after a trigger during which none fires
//   TRIG          out one-CLK120-cycle trigger pulse
//   OCC_OUT       out current occupancy count
module tot_trigger_multi
  import tot_trigger_multi_pkg::*;
#(
  parameter int NCH    = TOT_NCH,
  parameter int ADC_W  = TOT_ADC_W,
  parameter int WIN    = TOT_WIN,
  parameter int OCC_W  = TOT_OCC_W,
  parameter int MULT_W = TOT_MULT_W,
  parameter int HOLD_W = TOT_HOLD_W
) (
  input  logic                 CLK120,
  input  logic                 RESET_N,
  input  logic                 SAMPLE_EN,
  input  logic [NCH*ADC_W-1:0] ADC,
  input  logic [NCH*ADC_W-1:0] THRES,
  input  logic [NCH-1:0]       TRIG_ENABLE,
  input  logic [MULT_W-1:0]    MULTIPLICITY,
  input  logic [OCC_W-1:0]     OCCUPANCY,
  input  logic [HOLD_W-1:0]    HOLDOFF,
  output logic                 TRIG,
  output logic [OCC_W-1:0]     OCC_OUT
);

  logic [NCH*ADC_W-1:0] adc_q;
  logic [NCH*ADC_W-1:0] thr_q;
  logic [NCH-1:0]       pmt_nxt;
  logic [NCH-1:0]       pmt_trig;
  logic [MULT_W-1:0]    sum;
  logic                 sb;
  logic [OCC_W-1:0]     occ;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 trig_now;
  logic                 trig_now_q;
  logic                 trig_prev;

  // Strictly-greater unsigned compare per channel, masked by its enable.
  always_comb begin
    pmt_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      pmt_nxt[i] = (adc_q[i*ADC_W +: ADC_W] > thr_q[i*ADC_W +: ADC_W]) && TRIG_ENABLE[i];
    end
  end

  // Decided from the freshly updated occupancy; on the strobe it is true the
  // window is emptied and the holdoff armed, and the decision itself is
  // registered so the pulse lands one strobe later.
  assign trig_now = (occ > OCCUPANCY) && (hold_cnt == '0);

  always_ff @(posedge CLK120) begin
    if (!RESET_N) begin
      adc_q      <= '0;
      thr_q      <= '0;
      pmt_trig   <= '0;
      sum        <= '0;
      sb         <= 1'b0;
      hold_cnt   <= '0;
      trig_now_q <= 1'b0;
      trig_prev  <= 1'b0;
      TRIG       <= 1'b0;
    end else begin
      // TRIG is a single CLK120-cycle pulse: it drops on every non-strobe edge.
      TRIG <= 1'b0;
      if (SAMPLE_EN) begin
        adc_q      <= ADC;
        thr_q      <= THRES;
        pmt_trig   <= pmt_nxt;
        sum        <= MULT_W'(popcount(TOT_MAX_NCH'(pmt_trig)));
        sb         <= (sum >= MULTIPLICITY) && (MULTIPLICITY != '0);
        trig_now_q <= trig_now;
        trig_prev  <= trig_now_q;
        TRIG       <= trig_now_q && !trig_prev;
        if (trig_now) begin
          hold_cnt <= HOLDOFF;
        end else if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
        end
      end
    end
  end

  tot_occ_window #(
    .WIN   (WIN),
    .OCC_W (OCC_W)
  ) u_occ_window (
    .CLK120    (CLK120),
    .RESET_N   (RESET_N),
    .SAMPLE_EN (SAMPLE_EN),
    .SB        (sb),
    .CLR       (trig_now),
    .OCC       (occ)
  );

  assign OCC_OUT = occ;

endmodule

// File: tb/tb_tot_trigger_multi.sv
// Directed self-checking bench for tot_trigger_multi.
// Latency: n/a.
// Backpressure: n/a.
module tb_tot_trigger_multi;

  localparam int NCH    = 3;
  localparam int ADC_W  = 12;
  localparam int WIN    = 120;
  localparam int OCC_W  = 7;
  localparam int MULT_W = 2;
  localparam int HOLD_W = 8;

  logic                 CLK120;
  logic                 RESET_N;
  logic                 SAMPLE_EN;
  logic [NCH*ADC_W-1:0] ADC;
  logic [NCH*ADC_W-1:0] THRES;
  logic [NCH-1:0]       TRIG_ENABLE;
  logic [MULT_W-1:0]    MULTIPLICITY;
  logic [OCC_W-1:0]     OCCUPANCY;
  logic [HOLD_W-1:0]    HOLDOFF;
  logic                 TRIG;
  logic [OCC_W-1:0]     OCC_OUT;

  int tests     = 0;
  int fails     = 0;
  int sidx      = 0;   // index of the most recent strobe edge
  int s0        = 0;   // strobe index of the first capture of the current test
  int bad_pulse = 0;   // TRIG seen high after a non-strobe edge
  int occ_max   = 0;
  bit compat    = 1'b1;
  int trig_q[$];       // strobe indices at which TRIG was seen
  int occ_tr[260];

  tot_trigger_multi #(
    .NCH    (NCH),
    .ADC_W  (ADC_W),
    .WIN    (WIN),
    .OCC_W  (OCC_W),
    .MULT_W (MULT_W),
    .HOLD_W (HOLD_W)
  ) dut (
    .CLK120       (CLK120),
    .RESET_N      (RESET_N),
    .SAMPLE_EN    (SAMPLE_EN),
    .ADC          (ADC),
    .THRES        (THRES),
    .TRIG_ENABLE  (TRIG_ENABLE),
    .MULTIPLICITY (MULTIPLICITY),
    .OCCUPANCY    (OCCUPANCY),
    .HOLDOFF      (HOLDOFF),
    .TRIG         (TRIG),
    .OCC_OUT      (OCC_OUT)
  );

  initial CLK120 = 1'b0;
  always #5 CLK120 = ~CLK120;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_adc(input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2);
    ADC = {a2, a1, a0};
  endtask

  // One strobe: in compat mode followed by two idle CLK120 cycles.
  task automatic strobe();
    SAMPLE_EN = 1'b1;
    @(posedge CLK120); #1;
    sidx++;
    if (TRIG === 1'b1) trig_q.push_back(sidx);
    if (compat) begin
      SAMPLE_EN = 1'b0;
      repeat (2) begin
        @(posedge CLK120); #1;
        if (TRIG !== 1'b0) bad_pulse++;
      end
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    @(posedge CLK120); #1;
    RESET_N = 1'b1;
    trig_q.delete();
  endtask

  function automatic int trig_rel(input int k);
    if (k < trig_q.size()) return trig_q[k] - s0;
    return -1;
  endfunction

  initial begin
    RESET_N      = 1'b0;
    SAMPLE_EN    = 1'b0;
    set_adc(0, 0, 0);
    THRES        = {3{12'd100}};
    TRIG_ENABLE  = 3'b111;
    MULTIPLICITY = 2'd1;
    OCCUPANCY    = 7'd0;
    HOLDOFF      = 8'd0;
    repeat (2) @(posedge CLK120);
    #1;
    do_reset();
    check("rst_trig", TRIG, 0);
    check("rst_occ", OCC_OUT, 0);

    // 1: compat strobe, single ch0 sample over threshold
    s0 = sidx + 1;
    set_adc(200, 0, 0);
    strobe();
    set_adc(0, 0, 0);
    repeat (4) strobe();
    check("t1_occ_in", OCC_OUT, 1);
    strobe();
    check("t1_occ_clr", OCC_OUT, 0);
    repeat (6) strobe();
    check("t1_ntrig", trig_q.size(), 1);
    check("t1_latency", trig_rel(0), 6);
    check("t1_occ_end", OCC_OUT, 0);

    // 2: full rate, two channels for 13 samples, MULT=2, OCC=12
    compat       = 1'b0;
    SAMPLE_EN    = 1'b1;
    MULTIPLICITY = 2'd2;
    OCCUPANCY    = 7'd12;
    do_reset();
    s0 = sidx + 1;
    for (int j = 0; j < 30; j++) begin
      if (j < 13) set_adc(200, 200, 0); else set_adc(0, 0, 0);
      strobe();
      if (j == 15) check("t2_occ12", OCC_OUT, 12);
    end
    check("t2_ntrig", trig_q.size(), 1);
    check("t2_latency", trig_rel(0), 18);
    check("t2_occ_end", OCC_OUT, 0);

    // 2b: same with one channel only
    do_reset();
    s0 = sidx + 1;
    for (int j = 0; j < 25; j++) begin
      if (j < 13) set_adc(200, 0, 0); else set_adc(0, 0, 0);
      strobe();
    end
    check("t2b_occ", OCC_OUT, 0);
    check("t2b_ntrig", trig_q.size(), 0);

    // 3: 13 isolated samples 10 apart, window expiry
    MULTIPLICITY = 2'd1;
    do_reset();
    s0 = sidx + 1;
    occ_max = 0;
    for (int j = 0; j < 260; j++) begin
      set_adc(((j % 10) == 0 && j <= 120) ? 12'd200 : 12'd0, 0, 0);
      strobe();
      occ_tr[j] = int'(OCC_OUT);
      if (occ_tr[j] > occ_max) occ_max = occ_tr[j];
    end
    check("t3_occ_113", occ_tr[113], 11);
    check("t3_occ_114", occ_tr[114], 12);
    check("t3_occ_124", occ_tr[124], 12);
    check("t3_occ_133", occ_tr[133], 12);
    check("t3_occ_134", occ_tr[134], 11);
    check("t3_occ_243", occ_tr[243], 1);
    check("t3_occ_244", occ_tr[244], 0);
    check("t3_occ_max", occ_max, 12);
    check("t3_ntrig", trig_q.size(), 0);

    // 4: continuous input, OCC=3, HOLDOFF=20 (window keeps filling in holdoff)
    OCCUPANCY = 7'd3;
    HOLDOFF   = 8'd20;
    do_reset();
    s0 = sidx + 1;
    for (int j = 0; j < 60; j++) begin
      set_adc(200, 0, 0);
      strobe();
      if (j == 28) check("t4_occ_hold", OCC_OUT, 20);
    end
    check("t4_ntrig", trig_q.size(), 3);
    check("t4_trig0", trig_rel(0), 9);
    check("t4_trig1", trig_rel(1), 30);
    check("t4_trig2", trig_rel(2), 51);

    // 4b: HOLDOFF=0
    HOLDOFF = 8'd0;
    do_reset();
    s0 = sidx + 1;
    for (int j = 0; j < 25; j++) begin
      set_adc(200, 0, 0);
      strobe();
    end
    check("t4b_ntrig", trig_q.size(), 4);
    check("t4b_trig1", trig_rel(1), 14);
    check("t4b_trig3", trig_rel(3), 24);

    // 5: ADC equal to threshold
    OCCUPANCY = 7'd0;
    do_reset();
    set_adc(100, 100, 100);
    repeat (15) strobe();
    check("t5_eq_occ", OCC_OUT, 0);
    check("t5_eq_ntrig", trig_q.size(), 0);

    // 5b: MULTIPLICITY=0 disables
    MULTIPLICITY = 2'd0;
    do_reset();
    set_adc(4095, 4095, 4095);
    repeat (15) strobe();
    check("t5b_occ", OCC_OUT, 0);
    check("t5b_ntrig", trig_q.size(), 0);

    // 5c: channel disabled
    MULTIPLICITY = 2'd1;
    TRIG_ENABLE  = 3'b110;
    do_reset();
    set_adc(200, 0, 0);
    repeat (15) strobe();
    check("t5c_occ", OCC_OUT, 0);
    check("t5c_ntrig", trig_q.size(), 0);
    TRIG_ENABLE = 3'b111;

    // 6: reset mid-window, then full-rate repeat of test 1
    OCCUPANCY = 7'd50;
    do_reset();
    s0 = sidx + 1;
    for (int j = 0; j < 20; j++) begin
      if (j < 10) set_adc(200, 0, 0); else set_adc(0, 0, 0);
      strobe();
    end
    check("t6_occ10", OCC_OUT, 10);
    SAMPLE_EN = 1'b0;
    set_adc(200, 0, 0);
    repeat (10) begin
      @(posedge CLK120); #1;
    end
    check("t6_freeze_occ", OCC_OUT, 10);
    check("t6_freeze_trig", TRIG, 0);
    set_adc(0, 0, 0);
    SAMPLE_EN = 1'b1;
    RESET_N   = 1'b0;
    @(posedge CLK120); #1;
    RESET_N   = 1'b1;
    check("t6_rst_occ", OCC_OUT, 0);
    check("t6_rst_trig", TRIG, 0);
    OCCUPANCY = 7'd0;
    trig_q.delete();
    s0 = sidx + 1;
    set_adc(200, 0, 0);
    strobe();
    set_adc(0, 0, 0);
    repeat (4) strobe();
    check("t6_occ_in", OCC_OUT, 1);
    strobe();
    check("t6_occ_clr", OCC_OUT, 0);
    strobe();
    check("t6_trig_hi", TRIG, 1);
    check("t6_latency", trig_rel(0), 6);
    strobe();
    check("t6_trig_lo", TRIG, 0);

    check("compat_pulse_width", bad_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
